adder_seq_ctrl: RTL and testbench

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one shared Adder_4bit instance, one nibble per clock, LSB nibble first. It owns a carry register, operand and result shift registers, and a start/done handshake. It serves as the arithmetic unit for blocks that need wide add/sub without replicating the 4-bit adder.

---
 rtl/adder_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
//   Multi-cycle WIDTH-bit add/subtract built around one shared 4-bit adder.
//   Each operation is processed one nibble per clock, least significant nibble
//   first, with the adder's carry kept in a register between nibbles.
//   Subtraction is A + ~B + 1: B is inverted when it is latched and the +1
//   enters as the initial carry.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   operation request, accepted only while ready=1
//   sub     in   0: A+B, 1: A-B (latched with start)
//   A, B    in   operands, 4*NIBBLES bits (latched with start)
//   ready   out  idle and able to accept start
//   busy    out  operation in progress (RUN or DONE)
//   done    out  one-cycle completion pulse
//   Result  out  sum/difference; valid from done until the next accepted start
//   Cout    out  final carry (for subtraction 1 = no borrow)
//   Ovf     out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Result,
    output logic                   Cout,
    output logic                   Ovf
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d;          // operand A, shifted right one nibble per RUN cycle
    logic [W-1:0]      b_q, b_d;          // operand B' (B or ~B), shifted the same way
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;  // sign bit of B' (after optional inversion)

    logic [3:0]        add_sum;
    logic              add_cout;

    // The single shared adder always works on the low nibble of the
    // shift registers, so no wide operand multiplexer is needed.
    Adder_4bit u_adder (
        .A    (a_q[3:0]),
        .B    (b_q[3:0]),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub;             // supplies the +1 of A + ~B + 1
                    a_msb_d = A[W-1];
                    b_msb_d = sub ? ~B[W-1] : B[W-1];
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy = 1'b1;
                // Write the adder output into the slice selected by idx_q.
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        result_d[4*i +: 4] = add_sum;
                    end
                end
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = add_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // add_sum[3] is the sign bit of the final result here.
                    cout_d  = add_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (add_sum[3] != a_msb_q);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Result = result_q;
    assign Cout   = cout_q;
    assign Ovf    = ovf_q;

endmodule

// -----------------------------------------------------------------------------
// Adder_4bit
//   Plain 4-bit ripple adder with carry in/out; the only arithmetic element
//   of the sequencer datapath.
//
// Ports
//   A, B   in   4-bit addends
//   Cin    in   carry in
//   Sum    out  4-bit sum
//   Cout   out  carry out
// -----------------------------------------------------------------------------
module Adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  Result;
    logic          Cout;
    logic          Ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle_cnt = 0;
    int done_cnt = 0;

    adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Cout   (Cout),
        .Ovf    (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge (sample/drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done. Returns the number of
    // edges after the start edge until done is seen, the captured outputs and
    // the cycle count at done. Leaves the bench just after the DONE->IDLE edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output logic [W-1:0] res,
                          output logic co, output logic ov, output int dcyc);
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        A = a; B = b; sub = s; start = 1'b1;
        step();
        start = 1'b0;
        A = ~a; B = ~b; sub = ~s;   // later changes must not matter
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        res  = Result;
        co   = Cout;
        ov   = Ovf;
        dcyc = cycle_cnt;
        $display("op A=%h B=%h sub=%0d -> Result=%h Cout=%0d Ovf=%0d latency=%0d",
                 a, b, s, res, co, ov, lat);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        step(); step();
        n_cmp += 6;
        if (ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
        if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        if (Result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h expected 0000", Result); end
        if (Cout !== 1'b0)   begin n_bad++; $display("FAIL reset_cout: got %b expected 0", Cout); end
        if (Ovf !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", Ovf); end
        rst = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_add();
        logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [W-1:0] vb [3] = '{16'h0FCD, 16'h0001, 16'h0001};
        logic [W-1:0] er [3] = '{16'h2201, 16'h0000, 16'h8000};
        logic         ec [3] = '{1'b0, 1'b1, 1'b0};
        logic         eo [3] = '{1'b0, 1'b0, 1'b1};
        int lat, dcyc;
        logic [W-1:0] res;
        logic co, ov;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, res, co, ov, dcyc);
            n_cmp += 5;
            if (lat !== NIBBLES) begin n_bad++; $display("FAIL add_latency[%0d]: got %0d expected %0d", i, lat, NIBBLES); end
            if (res !== er[i])   begin n_bad++; $display("FAIL add_result[%0d]: got %h expected %h", i, res, er[i]); end
            if (co !== ec[i])    begin n_bad++; $display("FAIL add_cout[%0d]: got %b expected %b", i, co, ec[i]); end
            if (ov !== eo[i])    begin n_bad++; $display("FAIL add_ovf[%0d]: got %b expected %b", i, ov, eo[i]); end
            if (ready !== 1'b1)  begin n_bad++; $display("FAIL add_ready_after[%0d]: got %b expected 1", i, ready); end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] va [2] = '{16'h0005, 16'h8000};
        logic [W-1:0] vb [2] = '{16'h0007, 16'h0001};
        logic [W-1:0] er [2] = '{16'hFFFE, 16'h7FFF};
        logic         ec [2] = '{1'b0, 1'b1};
        logic         eo [2] = '{1'b0, 1'b1};
        int lat, dcyc;
        logic [W-1:0] res;
        logic co, ov;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], 1'b1, lat, res, co, ov, dcyc);
            n_cmp += 4;
            if (lat !== NIBBLES) begin n_bad++; $display("FAIL sub_latency[%0d]: got %0d expected %0d", i, lat, NIBBLES); end
            if (res !== er[i])   begin n_bad++; $display("FAIL sub_result[%0d]: got %h expected %h", i, res, er[i]); end
            if (co !== ec[i])    begin n_bad++; $display("FAIL sub_cout[%0d]: got %b expected %b", i, co, ec[i]); end
            if (ov !== eo[i])    begin n_bad++; $display("FAIL sub_ovf[%0d]: got %b expected %b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_ignored_start();
        int n, dc0;
        A = 16'h1111; B = 16'h2222; sub = 1'b0; start = 1'b1;
        dc0 = done_cnt;
        step();
        // Keep requesting a different operation through RUN and DONE.
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1;
        n_cmp += 2;
        if (busy !== 1'b1)  begin n_bad++; $display("FAIL ign_busy_run: got %b expected 1", busy); end
        if (ready !== 1'b0) begin n_bad++; $display("FAIL ign_ready_run: got %b expected 0", ready); end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        step();             // DONE -> IDLE with start still high
        start = 1'b0;
        n_cmp += 3;
        if (n !== NIBBLES)       begin n_bad++; $display("FAIL ign_latency: got %0d expected %0d", n, NIBBLES); end
        if (ready !== 1'b1)      begin n_bad++; $display("FAIL ign_ready_idle: got %b expected 1", ready); end
        if (Result !== 16'h3333) begin n_bad++; $display("FAIL ign_result: got %h expected 3333", Result); end
        for (int i = 0; i < 8; i++) step();
        n_cmp += 2;
        if (done_cnt - dc0 !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt - dc0); end
        if (Result !== 16'h3333)  begin n_bad++; $display("FAIL ign_result_hold: got %h expected 3333", Result); end
        $display("op A=1111 B=2222 sub=0 with extra starts -> Result=%h", Result);
    endtask

    task automatic test_abort();
        int dc0, lat, dcyc;
        logic [W-1:0] res;
        logic co, ov;
        A = 16'hAAAA; B = 16'h5555; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();      // two nibbles written
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (Result !== 16'h0000) begin n_bad++; $display("FAIL abort_result: got %h expected 0000", Result); end
        if (ready !== 1'b1)      begin n_bad++; $display("FAIL abort_ready: got %b expected 1", ready); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (done !== 1'b0)       begin n_bad++; $display("FAIL abort_done: got %b expected 0", done); end
        dc0 = done_cnt;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        n_cmp += 1;
        if (done_cnt !== dc0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - dc0); end
        $display("abort after two RUN cycles, Result=%h", Result);
        run_op(16'h0F0F, 16'h00F1, 1'b0, lat, res, co, ov, dcyc);
        n_cmp += 3;
        if (lat !== NIBBLES)  begin n_bad++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, NIBBLES); end
        if (res !== 16'h1000) begin n_bad++; $display("FAIL abort_next_result: got %h expected 1000", res); end
        if (co !== 1'b0)      begin n_bad++; $display("FAIL abort_next_cout: got %b expected 0", co); end
    endtask

    task automatic test_back_to_back();
        int prev, lat, dcyc;
        logic [W-1:0] a, b, bp, res, exp_r;
        logic s, co, ov, exp_c, exp_o;
        logic [W:0] full;
        prev = -1;
        for (int i = 0; i < 50; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom_range(0, 1));
            bp    = s ? ~b : b;
            full  = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
            exp_r = full[W-1:0];
            exp_c = full[W];
            exp_o = (a[W-1] == bp[W-1]) && (exp_r[W-1] != a[W-1]);
            run_op(a, b, s, lat, res, co, ov, dcyc);
            n_cmp += 4;
            if (res !== exp_r) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, exp_r); end
            if (co !== exp_c)  begin n_bad++; $display("FAIL b2b_cout[%0d]: got %b expected %b", i, co, exp_c); end
            if (ov !== exp_o)  begin n_bad++; $display("FAIL b2b_ovf[%0d]: got %b expected %b", i, ov, exp_o); end
            if (lat !== NIBBLES) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, NIBBLES); end
            if (prev >= 0) begin
                n_cmp++;
                if (dcyc - prev !== NIBBLES + 2) begin
                    n_bad++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, dcyc - prev, NIBBLES + 2);
                end
            end
            prev = dcyc;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
